ide_dma_engine: RTL
===================

Name: ide_dma_engine

Overview:
- Multiword-DMA sequencer for the IDE device side. Drives the DMARQ request, tracks DMACK_ and DIOR_/DIOW_ strobes, and steps the 256x16 sector buffer address for each transferred word.
- Sits between the AVR control registers (start, direction, count, start address) and the IDE pin layer. Its outputs feed the DMARQ control pin, dd_out/dd_enable gating and the data buffer port.
- Consumes pin inputs that are already synchronised, active-low.

Parameters:
- ADDR_W, 8, buffer word-address width; the address wraps modulo 2^ADDR_W.
- CNT_W, 9, word-count width; allows 0..256 words.
- TIMEOUT_W, 20, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse from AVR; starts a transfer
- abort  in  1  one-cycle pulse from AVR; cancels the transfer
- dir  in  1  sampled at start: 0 = host reads (DIOR_ strobes), 1 = host writes (DIOW_ strobes)
- word_count  in  CNT_W  number of words to transfer
- start_addr  in  ADDR_W  first buffer word address
- dmack_n  in  1  synchronised DMACK_
- dior_n  in  1  synchronised DIOR_
- diow_n  in  1  synchronised DIOW_
- dmarq  out  1  DMARQ assert request (enable for the DMARQ control pin)
- dma_drive  out  1  high while dir=0, DMACK_ low and DIOR_ low; drive dd
- buf_addr  out  ADDR_W  current buffer word address
- buf_we  out  1  one-cycle pulse: latch dd into buffer at buf_addr (dir=1 only)
- busy  out  1  high in any state except IDLE
- remaining  out  CNT_W  words still to transfer
- done  out  1  one-cycle pulse at transfer completion or abort
- err  out  1  sticky; set on abort or timeout, cleared by the next accepted start

Behaviour:
- Edge detection: register {dmack_n, dior_n, diow_n} once (prev), compare with current.
  - Strobe start = 1->0 transition of the strobe selected by dir.
  - Strobe end = 0->1 transition of the selected strobe.
  - A strobe edge counts only when dmack_n is low in both prev and current samples. Edges on the non-selected strobe are ignored.
- Reset values: dmarq=0, dma_drive=0, buf_addr=0, buf_we=0, busy=0, remaining=0, done=0, err=0, state IDLE, edge registers all 1.
- IDLE:
  - start and word_count=0: done pulses next cycle; stay IDLE.
  - start and word_count>0: latch dir, remaining<=word_count, buf_addr<=start_addr, err<=0; go to REQ. dmarq=1 from the following cycle.
  - start while not IDLE is ignored.
- REQ: dmarq=1. dmack_n low -> XFER.
- XFER:
  - Strobe start with remaining=1: dmarq<=0 next cycle.
  - Strobe end: remaining<=remaining-1 and buf_addr<=buf_addr+1 (wraps 2^ADDR_W-1 -> 0). If dir=1, buf_we pulses the same cycle using the pre-increment address.
  - Strobe end with remaining=1 -> DRAIN.
  - dmack_n rising while remaining>0 and no strobe active -> REQ (host pause; dmarq stays/returns to 1).
- DRAIN: dmarq=0; wait for dmack_n high, then done pulse and go to IDLE.
- abort in any non-IDLE state: next cycle dmarq=0, err=1, done pulse, state IDLE. remaining and buf_addr hold their values for AVR readback.
- abort together with start in IDLE: abort wins; start is ignored.
- dma_drive is combinational from current synchronised inputs and latched dir. It is gated to 0 in IDLE and DRAIN.
- rst mid-transfer: all outputs return to reset values on the next clock edge, including dmarq=0.

Optional Feature:
- Macro IDE_DMA_TIMEOUT_EN.
- Defined: a TIMEOUT_W-bit counter clears on every counted strobe edge and on entry to REQ, and increments in REQ/XFER. At all-ones it behaves exactly as abort: err=1, done pulse, IDLE.
- Undefined: no counter; the engine waits indefinitely.

Test Plan:
- dir=0, count=4, addr=0x10; host does 4 DMACK_/DIOR_ cycles -> buf_addr 0x10..0x14; dmarq drops after the 4th DIOR_ fall; done once DMACK_ high; remaining=0, err=0.
- dir=1, count=2, addr=0xFF -> buf_we at 0xFF then 0x00 (wrap); buf_addr ends 0x01.
- count=3; host deasserts DMACK_ after word 1 -> state REQ, dmarq stays 1, remaining=2; resume and finish normally.
- abort after 2 of 5 words -> dmarq 0 next cycle, err=1, done pulse, remaining=3; next start clears err.
- start with count=0 -> done pulse, dmarq never asserted. start+abort in the same cycle -> stays IDLE, dmarq=0. DIOW_ strobes during dir=0 -> ignored.
- IDE_DMA_TIMEOUT_EN with TIMEOUT_W=4: REQ with no DMACK_ for 15 cycles -> err=1, done, IDLE. rst mid-XFER -> all outputs zero next cycle.

Source files
------------

// File: rtl/ide_dma_engine.sv
// ide_dma_engine: multiword-DMA sequencer for the IDE device side.
//
// The engine raises DMARQ and follows the host's DMACK_ and DIOR_/DIOW_ strobes. It steps the
// sector-buffer word address once per transferred word. The AVR starts and aborts transfers
// through one-cycle pulses. All pin inputs arrive already synchronised and are active-low.
//
// Optional build macro:
//   IDE_DMA_TIMEOUT_EN - adds a TIMEOUT_W-bit watchdog. It aborts a stalled REQ/XFER phase.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, abort        one-cycle control pulses from the AVR
//   dir                 latched at start: 0 = host reads (DIOR_), 1 = host writes (DIOW_)
//   word_count          words to transfer (0..2^(CNT_W-1))
//   start_addr          first buffer word address
//   dmack_n, dior_n,
//   diow_n              synchronised host pins
//   dmarq               DMARQ request enable
//   dma_drive           drive dd toward the host (read data phase)
//   buf_addr            current buffer word address (wraps)
//   buf_we              write strobe into the buffer at buf_addr (host-write direction)
//   busy                engine not idle
//   remaining           words still to transfer
//   done                one-cycle completion/abort pulse
//   err                 sticky abort/timeout flag, cleared by the next accepted start
module ide_dma_engine #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned CNT_W     = 9,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dir,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              dmack_n,
    input  logic              dior_n,
    input  logic              diow_n,
    output logic              dmarq,
    output logic              dma_drive,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic              busy,
    output logic [CNT_W-1:0]  remaining,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic              dmarq_q, dmarq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Previous samples of the pins for edge detection.
    logic dmack_p, dior_p, diow_p;

    logic sel_cur, sel_prev, ack_held, stb_fall, stb_rise, ack_rise, last_word, active;
    logic tmo_hit;

    // Only the strobe selected by the latched direction is followed. Its edges count only while
    // DMACK_ was low in both samples.
    assign sel_cur   = dir_q ? diow_n : dior_n;
    assign sel_prev  = dir_q ? diow_p : dior_p;
    assign ack_held  = !dmack_n && !dmack_p;
    assign stb_fall  = ack_held && sel_prev && !sel_cur;
    assign stb_rise  = ack_held && !sel_prev && sel_cur;
    assign ack_rise  = !dmack_p && dmack_n;
    assign last_word = (rem_q == CNT_W'(1));
    assign active    = (state_q == ST_REQ) || (state_q == ST_XFER);

`ifdef IDE_DMA_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q;

    assign tmo_hit = active && (&tmo_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (((state_d == ST_REQ) && (state_q != ST_REQ)) || stb_fall || stb_rise) begin
            tmo_q <= '0;
        end else if (active) begin
            tmo_q <= tmo_q + TIMEOUT_W'(1);
        end
    end
`else
    logic unused_tmo_w;

    assign tmo_hit      = 1'b0;
    assign unused_tmo_w = (TIMEOUT_W != 0);
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dmarq_d = dmarq_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if ((state_q != ST_IDLE) && (abort || tmo_hit)) begin
            // remaining and buf_addr are held for readback.
            state_d = ST_IDLE;
            dmarq_d = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (word_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            dir_d   = dir;
                            rem_d   = word_count;
                            addr_d  = start_addr;
                            err_d   = 1'b0;
                            dmarq_d = 1'b1;
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    dmarq_d = 1'b1;
                    if (!dmack_n) begin
                        state_d = ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Withdraw the request as soon as the host starts the final word.
                    if (stb_fall && last_word) begin
                        dmarq_d = 1'b0;
                    end
                    if (stb_rise) begin
                        rem_d  = rem_q - CNT_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        if (last_word) begin
                            dmarq_d = 1'b0;
                            state_d = ST_DRAIN;
                        end
                    end else if (ack_rise && sel_cur) begin
                        // Host paused between words: go back to requesting.
                        dmarq_d = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    dmarq_d = 1'b0;
                    if (dmack_n) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            dmarq_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dmack_p <= 1'b1;
            dior_p  <= 1'b1;
            diow_p  <= 1'b1;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dmarq_q <= dmarq_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dmack_p <= dmack_n;
            dior_p  <= dior_n;
            diow_p  <= diow_n;
        end
    end

    assign dmarq     = dmarq_q;
    assign dma_drive = active && !dir_q && !dmack_n && !dior_n;
    // Write happens on the strobe's rising edge, before the address increments.
    assign buf_we    = (state_q == ST_XFER) && stb_rise && dir_q;
    assign buf_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign remaining = rem_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
